// File: rtl/matrix_operand_loader.sv
// Serial operand stream to parallel A/B registers for matrix_mult, with c_valid strobe.
// Optional in_last framing check: define LOADER_LAST_CHECK_EN.
module matrix_operand_loader #(
    parameter int N       = 4,
    parameter int WIDTH   = 16,
    parameter int LATENCY = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic [WIDTH-1:0] A [N][N],
    output logic [WIDTH-1:0] B [N][N],
    output logic             c_valid,
    output logic             busy,
    output logic             err
);
    localparam int NE = 2 * N * N;
    localparam int IW = $clog2(NE);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NE - 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT} state_t;

    state_t        state, state_n;
    logic [IW-1:0] idx, idx_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          ready_n, busy_n, cval_n, err_n;
    logic          accept, abort;

    assign accept = (state == LOAD) && in_valid && in_ready;

`ifdef LOADER_LAST_CHECK_EN
    // in_last early aborts the frame; a missing in_last only flags it
    assign abort = accept && in_last && (idx != LAST_IDX);
    assign err_n = err || (accept && (in_last != (idx == LAST_IDX)));
`else
    logic unused_last;
    assign unused_last = in_last;
    assign abort = 1'b0;
    assign err_n = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            c_valid  <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            cnt      <= cnt_n;
            in_ready <= ready_n;
            busy     <= busy_n;
            c_valid  <= cval_n;
            err      <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        cnt_n   = cnt;
        ready_n = in_ready;
        busy_n  = busy;
        cval_n  = 1'b0;
        unique case (state)
            IDLE: begin
                state_n = LOAD;
                ready_n = 1'b1;
            end
            LOAD: begin
                if (accept) begin
                    if (abort) begin
                        idx_n = '0;
                    end else if (idx == LAST_IDX) begin
                        state_n = WAIT;
                        ready_n = 1'b0;
                        busy_n  = 1'b1;
                        cnt_n   = CNT_INIT;
                        idx_n   = '0;
                    end else begin
                        idx_n = idx + 1'b1;
                    end
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    cval_n  = 1'b1;
                    busy_n  = 1'b0;
                    ready_n = 1'b1;
                    state_n = LOAD;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Row-major element store; A occupies indices 0..N*N-1, B the rest
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    A[i][j] <= '0;
                    B[i][j] <= '0;
                end
            end
        end else if (accept) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    if (idx == IW'(i * N + j))
                        A[i][j] <= in_data;
                    if (idx == IW'(N * N + i * N + j))
                        B[i][j] <= in_data;
                end
            end
        end
    end
endmodule
